arb_rr4: RTL

Four-requester arbiter sharing one resource (a bus, or the encoder datapath) among requesters `req[3:0]`. It grants exactly one requester at a time, holds the grant until that requester releases, and enforces a maximum hold time. It can run round-robin or fixed priority. It sits in front of the shared resource and drives that resource's select lines from `gnt_idx`.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_rr4_if.sv | 27 ++
 rtl/arb_prio_enc.sv | 21 ++
 rtl/arb_rr4.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 8;

endpackage

// File: rtl/arb_rr4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arb_rr4_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               busy;
    logic               timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output busy,
        output timeout
    );

endinterface

// File: rtl/arb_prio_enc.sv
// Combinational 4:2 priority encoder; the highest set bit wins.
module arb_prio_enc
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_rr4.sv
// Four-requester arbiter with hold timeout and per-requester lockout.
// ARB_RR_EN selects round-robin search; otherwise fixed priority (req[3] highest).
module arb_rr4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    arb_rr4_if.slave   bus
);

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic [NUM_REQ-1:0] lock_q, lock_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic               busy_q, busy_nxt;
    logic               tmo_q, tmo_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt, cnt_inc, cnt_sat;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] enc_in;
    logic [IDX_W-1:0]   enc_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic               grant_now;
    logic               owner_req;
    logic               hold_hit;

    assign elig      = bus.req & ~lock_q;
    assign grant_now = (state == IDLE) && win_vld;
    assign owner_req = bus.req[idx_q];
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_inc;
    assign hold_hit  = (MAX_HOLD_C != '0) && (cnt_inc == MAX_HOLD_C);

    arb_prio_enc u_enc (
        .vec (enc_in),
        .idx (enc_idx),
        .vld (win_vld)
    );

`ifdef ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_nxt;

    // Pointer position lands on encoder bit 3 so the search starts there and wraps.
    always_comb begin
        enc_in = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            enc_in[NUM_REQ-1-k] = elig[IDX_W'(ptr_q + IDX_W'(k))];
        end
    end

    assign win_idx = ptr_q + (IDX_W'(NUM_REQ-1) - enc_idx);
    assign ptr_nxt = grant_now ? (win_idx + IDX_W'(1)) : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end
`else
    assign enc_in  = elig;
    assign win_idx = enc_idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            tmo_q  <= 1'b0;
            lock_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_nxt;
            idx_q  <= idx_nxt;
            busy_q <= busy_nxt;
            tmo_q  <= tmo_nxt;
            lock_q <= lock_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        idx_nxt   = idx_q;
        busy_nxt  = busy_q;
        tmo_nxt   = 1'b0;
        cnt_nxt   = cnt_q;
        lock_nxt  = lock_q & bus.req;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = NUM_REQ'(1) << win_idx;
                    idx_nxt   = win_idx;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                // A release on the limit cycle wins over the timeout.
                if (!owner_req) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else if (hold_hit) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    tmo_nxt   = 1'b1;
                    lock_nxt  = lock_nxt | gnt_q;
                end else begin
                    cnt_nxt = cnt_sat;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = tmo_q;

endmodule
